// File: rtl/input_conditioner.sv
// Two-channel A0/A1 input conditioner: 2-FF synchronizer plus independent
// debounce counter per channel, with change pulses and a combined settled flag.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a0_raw,
  input  logic a1_raw,
  output logic a0_o,
  output logic a1_o,
  output logic a0_changed,
  output logic a1_changed,
  output logic settled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       out;
  logic [1:0]       changed;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {a1_raw, a0_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      out     <= '0;
      changed <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < 2; i++) begin
        // A return to the current output level discards any partial count.
        if (s2[i] == out[i]) begin
          cnt[i]     <= '0;
          changed[i] <= 1'b0;
        end else if (cnt[i] == CNT_MAX) begin
          out[i]     <= s2[i];
          cnt[i]     <= '0;
          changed[i] <= 1'b1;
        end else begin
          cnt[i]     <= cnt[i] + CNT_W'(1);
          changed[i] <= 1'b0;
        end
      end
    end
  end

  assign a0_o       = out[0];
  assign a1_o       = out[1];
  assign a0_changed = changed[0];
  assign a1_changed = changed[1];
  assign settled    = (s2[0] == out[0]) && (s2[1] == out[1]);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4; edge indices
// are counted from E0, the first edge that captures a new raw level.
module tb_input_conditioner;

  logic clk;
  logic rst_n;
  logic a0_raw;
  logic a1_raw;
  logic a0_o;
  logic a1_o;
  logic a0_changed;
  logic a1_changed;
  logic settled;

  int passed;
  int total;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a0_raw     (a0_raw),
    .a1_raw     (a1_raw),
    .a0_o       (a0_o),
    .a1_o       (a1_o),
    .a0_changed (a0_changed),
    .a1_changed (a1_changed),
    .settled    (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_to(input logic v0, input logic v1);
    a0_raw = v0;
    a1_raw = v1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    logic exp_o, exp_ch, exp_s;
    rst_n  = 1'b0;
    a0_raw = 1'b1;
    a1_raw = 1'b1;
    repeat (3) tick();
    total++; if (a0_o !== 1'b0) $display("FAIL reset_a0_o got %b exp 0", a0_o); else passed++;
    total++; if (a1_o !== 1'b0) $display("FAIL reset_a1_o got %b exp 0", a1_o); else passed++;
    total++; if (a0_changed !== 1'b0) $display("FAIL reset_a0_changed got %b exp 0", a0_changed); else passed++;
    total++; if (a1_changed !== 1'b0) $display("FAIL reset_a1_changed got %b exp 0", a1_changed); else passed++;
    total++; if (settled !== 1'b1) $display("FAIL reset_settled got %b exp 1", settled); else passed++;
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp_o  = (e >= 5);
      exp_ch = (e == 5);
      exp_s  = !(e >= 1 && e < 5);
      total++; if (a0_o !== exp_o) $display("FAIL release_a0_o e=%0d got %b exp %b", e, a0_o, exp_o); else passed++;
      total++; if (a0_changed !== exp_ch) $display("FAIL release_a0_changed e=%0d got %b exp %b", e, a0_changed, exp_ch); else passed++;
      total++; if (a1_o !== exp_o) $display("FAIL release_a1_o e=%0d got %b exp %b", e, a1_o, exp_o); else passed++;
      total++; if (settled !== exp_s) $display("FAIL release_settled e=%0d got %b exp %b", e, settled, exp_s); else passed++;
    end
  endtask

  task automatic test_clean_rise();
    logic exp_o, exp_ch, exp_s;
    settle_to(1'b0, 1'b0);
    a0_raw = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_o  = (e >= 5);
      exp_ch = (e == 5);
      exp_s  = !(e >= 1 && e < 5);
      total++; if (a0_o !== exp_o) $display("FAIL rise_a0_o e=%0d got %b exp %b", e, a0_o, exp_o); else passed++;
      total++; if (a0_changed !== exp_ch) $display("FAIL rise_a0_changed e=%0d got %b exp %b", e, a0_changed, exp_ch); else passed++;
      total++; if (settled !== exp_s) $display("FAIL rise_settled e=%0d got %b exp %b", e, settled, exp_s); else passed++;
      total++; if (a1_o !== 1'b0) $display("FAIL rise_a1_o e=%0d got %b exp 0", e, a1_o); else passed++;
      total++; if (a1_changed !== 1'b0) $display("FAIL rise_a1_changed e=%0d got %b exp 0", e, a1_changed); else passed++;
    end
  endtask

  task automatic test_bounce();
    settle_to(1'b0, 1'b0);
    a0_raw = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 2) a0_raw = 1'b0;
      total++; if (a0_o !== 1'b0) $display("FAIL bounce_a0_o e=%0d got %b exp 0", e, a0_o); else passed++;
      total++; if (a0_changed !== 1'b0) $display("FAIL bounce_a0_changed e=%0d got %b exp 0", e, a0_changed); else passed++;
    end
    total++; if (settled !== 1'b1) $display("FAIL bounce_settled got %b exp 1", settled); else passed++;
  endtask

  task automatic test_simultaneous();
    logic exp_o;
    settle_to(1'b0, 1'b0);
    a0_raw = 1'b1;
    a1_raw = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_o = (e >= 5);
      total++; if (a0_o !== exp_o) $display("FAIL simul_a0_o e=%0d got %b exp %b", e, a0_o, exp_o); else passed++;
      total++; if (a1_o !== exp_o) $display("FAIL simul_a1_o e=%0d got %b exp %b", e, a1_o, exp_o); else passed++;
      total++; if ((a0_o ^ a1_o) !== 1'b0) $display("FAIL simul_xor e=%0d got %b exp 0", e, a0_o ^ a1_o); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic exp_o, exp_ch;
    settle_to(1'b0, 1'b0);
    a1_raw = 1'b1;
    repeat (4) tick();  // through E3: channel count is now 2
    total++; if (settled !== 1'b0) $display("FAIL midrst_pre_settled got %b exp 0", settled); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (settled !== 1'b1) $display("FAIL midrst_settled got %b exp 1", settled); else passed++;
    total++; if (a1_o !== 1'b0) $display("FAIL midrst_a1_o got %b exp 0", a1_o); else passed++;
    total++; if (a1_changed !== 1'b0) $display("FAIL midrst_a1_changed got %b exp 0", a1_changed); else passed++;
    #1;
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp_o  = (e >= 5);
      exp_ch = (e == 5);
      total++; if (a1_o !== exp_o) $display("FAIL midrst_rel_a1_o e=%0d got %b exp %b", e, a1_o, exp_o); else passed++;
      total++; if (a1_changed !== exp_ch) $display("FAIL midrst_rel_a1_changed e=%0d got %b exp %b", e, a1_changed, exp_ch); else passed++;
    end
  endtask

  task automatic test_fall();
    logic exp_o, exp_ch;
    settle_to(1'b1, 1'b0);
    total++; if (a0_o !== 1'b1) $display("FAIL fall_pre_a0_o got %b exp 1", a0_o); else passed++;
    a0_raw = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_o  = (e < 5);
      exp_ch = (e == 5);
      total++; if (a0_o !== exp_o) $display("FAIL fall_a0_o e=%0d got %b exp %b", e, a0_o, exp_o); else passed++;
      total++; if (a0_changed !== exp_ch) $display("FAIL fall_a0_changed e=%0d got %b exp %b", e, a0_changed, exp_ch); else passed++;
    end
    // Short re-toggle, 3 edges high, must be rejected.
    a0_raw = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 2) a0_raw = 1'b0;
      total++; if (a0_o !== 1'b0) $display("FAIL retoggle_a0_o e=%0d got %b exp 0", e, a0_o); else passed++;
      total++; if (a0_changed !== 1'b0) $display("FAIL retoggle_a0_changed e=%0d got %b exp 0", e, a0_changed); else passed++;
    end
    total++; if (settled !== 1'b1) $display("FAIL retoggle_settled got %b exp 1", settled); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    a0_raw = 1'b0;
    a1_raw = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_fall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Two-channel input conditioner that sits directly upstream of the desacople XOR decoder. It takes the raw, asynchronous A0/A1 switch levels from the board pins and synchronizes each one into the clock domain. It debounces each channel independently and presents clean levels for the decoder inputs. It also provides per-channel change pulses and a settled flag, so control logic and the bench can tell when the decoder output is trustworthy.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000, is the number of consecutive clock edges a synchronized level must differ from the current output before the output follows it. The default is 10 ms at 50 MHz. Legal range is ≥1.
- CNT_W, default max(1, $clog2(DEBOUNCE_CYCLES)), is the counter width. It is derived and must not be overridden.

Ports:
- clk, input, 1: system clock. The block has one clock; reset is asynchronous and active-low.
- rst_n, input, 1: asynchronous active-low reset.
- a0_raw, input, 1: raw A0 pin level, asynchronous to clk.
- a1_raw, input, 1: raw A1 pin level, asynchronous to clk.
- a0_o, output, 1: debounced A0, drives the decoder input A0.
- a1_o, output, 1: debounced A1, drives the decoder input A1.
- a0_changed, output, 1: one-cycle pulse, high in the cycle a0_o takes a new value.
- a1_changed, output, 1: one-cycle pulse, high in the cycle a1_o takes a new value.
- settled, output, 1: high when both channels have their synchronized level equal to their output.

## Operation
- Each channel has a 2-FF synchronizer (s1 → s2) that samples the raw input. Both flops reset to 0.
- Each channel has its own counter cnt[CNT_W-1:0] and output register out. The channels are fully independent and share only clk and rst_n.
- Per-channel states:
  - STABLE: cnt == 0 and s2 == out.
  - SETTLING: s2 != out, or cnt > 0.
- Per-channel update rule, evaluated every clock edge:
  - If s2 == out: cnt ← 0 and the channel goes to STABLE. This covers a bounce back to the old level, which discards any accumulated count.
  - Else if cnt == DEBOUNCE_CYCLES-1: out ← s2, cnt ← 0, changed ← 1, and the channel goes to STABLE.
  - Else: cnt ← cnt+1 and the channel stays in SETTLING.
  - changed is 0 on every edge where out is not updated.
- settled = (a0 s2 == a0_o) && (a1 s2 == a1_o). It is combinational from registers and has no glitch path from the raw inputs.
- The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- With DEBOUNCE_CYCLES = 1, out follows s2 on the first edge where they differ.
- Simultaneous change: if a0_raw and a1_raw toggle between the same pair of edges and are held, a0_o and a1_o update on the same edge. The downstream XOR therefore never sees an intermediate state.
- Skewed change: if the raw inputs toggle k cycles apart, the outputs update k cycles apart.
- Reset, including reset asserted mid-SETTLING:
  - All flops clear immediately: s1, s2, cnt = 0; a0_o, a1_o = 0; a0_changed, a1_changed = 0; settled = 1.
  - Any partial count is lost. After release, debouncing restarts from zero.

## Timing
- Take edge E0 as the first edge that samples the new raw level into s1.
- s2 updates at E1.
- out updates at edge E(1+DEBOUNCE_CYCLES), if the raw level is held throughout. Total latency is DEBOUNCE_CYCLES+1 edges from E0 (DEBOUNCE_CYCLES+2 edges counted from E(−1)).
- changed is high for exactly the cycle following the edge that updates out. It coincides with the first cycle of the new out value.
- settled goes low the cycle after E1. It returns high in the same cycle that out updates.
- A bounce (raw returns to the old level) resets the channel count one edge after it reaches s2.
- After reset release, the first capture edge is the first rising clk edge with rst_n high.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. Reset: hold rst_n = 0 with a0_raw = a1_raw = 1 → a0_o = a1_o = 0, both changed = 0, settled = 1. Then release rst_n with the raw levels held → a0_o rises at edge E5 after release (E0 = first capture edge). a0_changed is high for that single cycle.
2. Clean rise on a0: a0_raw 0→1 before E0, held → settled = 0 from after E1 to E5. a0_o = 1 after E5 with one a0_changed pulse. a1_o stays 0 with no a1_changed pulse.
3. Bounce reject: a0_raw high for exactly 3 edges, then low → a0_o stays 0, no a0_changed pulse, settled returns to 1.
4. Simultaneous rise: a0_raw and a1_raw both 0→1 before the same edge → a0_o and a1_o both become 1 on the same edge. The XOR of the outputs stays 0 on every cycle.
5. Reset mid-settling: a1_raw rises, then rst_n is pulsed low when cnt = 2 → outputs clear instantly. After release with a1_raw held at 1, a1_o rises at E5, not earlier.
6. Falling edge after stable high: a0_o = 1, then a0_raw → 0 held → a0_o = 0 at E5 with one a0_changed pulse. A second toggle 2 edges later is rejected if it is shorter than 4 edges.
